mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM pipeline stage of the 5-stage LoongArch core, sitting between EX and WB.
- Drives the transmitter side of the MEM→WB valid/allowin handshake and produces the 38-bit {we, waddr, wdata} bundle that WB consumes.
- Waits for data-SRAM responses of loads issued in EX, and buffers rdata if WB stalls.
- Extracts and extends load data, and exports forwarding and load-use info to ID.

Parameters:
- none (widths fixed by the ISA/pipeline bundles)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- es_to_ms_valid  in  1  EX has an instruction for MEM
- ms_allowin  out  1  MEM can accept from EX this cycle
- es_pc  in  32  EX instruction PC
- es_rf_collect  in  38  {we, waddr[4:0], alu_result[31:0]}
- es_mem_collect  in  6  {req_sent, ld_op[2:0], addr_lo[1:0]}
- data_sram_data_ok  in  1  load response valid (one pulse per accepted request)
- data_sram_rdata  in  32  load response data
- ws_allowin  in  1  WB can accept
- ms_to_ws_valid  out  1  MEM has a completed instruction for WB
- ms_pc  out  32  MEM instruction PC
- ms_rf_collect  out  38  {we, waddr, final wdata}
- ms_fwd_collect  out  38  {ms_valid & we, waddr, final wdata} to ID bypass
- ms_ld_pending  out  1  valid load in MEM whose data has not arrived; ID must stall on a matching source

Behaviour:
- Reset: ms_valid=0; ms_pc, rf/mem bundles = 0; data buffer empty.
  - All outputs then: ms_to_ws_valid=0, ms_allowin=1, ms_ld_pending=0, ms_rf_collect=0, ms_fwd_collect=0.
- ld_op encoding:
  - 000 non-load, 001 ld.b, 010 ld.h, 011 ld.w, 101 ld.bu, 110 ld.hu.
  - 100 and 111 are treated as non-load.
- wait = ms_valid & req_sent & (ld_op is a load).
  - Stores have req_sent=0 in the bundle (store response is not tracked here).
- ms_ready_go = ~wait | data_sram_data_ok | buf_valid.
- ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin).
- ms_to_ws_valid = ms_valid & ms_ready_go.
- Capture: when ms_allowin, ms_valid <= es_to_ms_valid. Bundles and pc are loaded only when es_to_ms_valid & ms_allowin.
- Data buffer (32-bit + buf_valid):
  - Set when wait & data_ok & ~ws_allowin & ~buf_valid.
  - Cleared when ms_to_ws_valid & ws_allowin.
  - A new data_ok while buf_valid=1 is a protocol violation; it is ignored.
- data_ok while not wait: ignored; no state change.
- Load data source: buf_valid ? buffer : data_sram_rdata.
- Byte select by addr_lo: 00→[7:0], 01→[15:8], 10→[23:16], 11→[31:24].
- Halfword select by addr_lo[1]: 0→[15:0], 1→[31:16].
- Extension: b/h sign-extend, bu/hu zero-extend, w passes through. Alignment is guaranteed by EX.
- final wdata = load ? extended data : alu_result.
- ms_ld_pending = wait & ~data_ok & ~buf_valid.
- Latency:
  - Non-load: 1 cycle in MEM if WB allows.
  - Load: completes in the cycle data_ok arrives, combinationally passing to WB.
- Back-to-back: the instruction leaving and a new one entering in the same cycle is allowed. The buffer clears on the same edge the new instruction loads.
- Reset mid-wait: the outstanding instruction is dropped. The external SRAM interface is reset by the same signal, so no stale data_ok arrives.

Optional Feature:
- Macro MS_PERF_CNT_EN.
- Defined:
  - Adds output ms_stall_cnt[31:0], reset to 0.
  - Increments (wraps at 2^32) each cycle ms_valid & ~ms_ready_go.
- Undefined: port and counter are absent; behaviour otherwise identical.

Test Plan:
- Non-load, ws_allowin=1: es_pc=0x1c000000, rf_collect={1,5'd3,0x12345678} → next cycle ms_to_ws_valid=1, ms_rf_collect={1,3,0x12345678}, ms_pc=0x1c000000.
- ld.b addr_lo=11, data_ok after 3 cycles with rdata=0x80FF0011:
  - ms_ld_pending=1 for 3 cycles, ms_ready_go=0 for those cycles.
  - Then wdata=0xFFFFFF80; with ld.bu → 0x00000080.
- ld.h addr_lo=10 with rdata=0x8001ABCD → 0xFFFF8001; ld.hu addr_lo=00 → 0x0000ABCD.
- data_ok arrives with ws_allowin=0 for 2 cycles, rdata=0xDEADBEEF, then rdata bus changes to 0:
  - Buffer holds; ms_to_ws_valid stays 1.
  - When ws_allowin rises, wdata=0xDEADBEEF; buf_valid clears.
- Assert reset during a pending load → next cycle ms_to_ws_valid=0, ms_allowin=1, ms_ld_pending=0.
- Stray data_ok with ms_valid=0 → no output or buffer change.
- With MS_PERF_CNT_EN defined, the 3-cycle-wait load above → ms_stall_cnt=3.

Source files
------------

// File: rtl/mem_stage_if.sv
// EX->MEM and MEM->WB valid/allowin handshake bundles.
// Members keep the pipeline signal names.
interface es_ms_if;
  logic        es_to_ms_valid;
  logic        ms_allowin;
  logic [31:0] es_pc;
  logic [37:0] es_rf_collect;
  logic [5:0]  es_mem_collect;

  modport master (
    output es_to_ms_valid,
    output es_pc,
    output es_rf_collect,
    output es_mem_collect,
    input  ms_allowin
  );

  modport slave (
    input  es_to_ms_valid,
    input  es_pc,
    input  es_rf_collect,
    input  es_mem_collect,
    output ms_allowin
  );
endinterface

interface ms_ws_if;
  logic        ms_to_ws_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic [37:0] ms_rf_collect;

  modport master (
    output ms_to_ws_valid,
    output ms_pc,
    output ms_rf_collect,
    input  ws_allowin
  );

  modport slave (
    input  ms_to_ws_valid,
    input  ms_pc,
    input  ms_rf_collect,
    output ws_allowin
  );
endinterface

// File: rtl/mem_stage.sv
// MEM stage: load response wait/buffer, load extension, WB handshake.
// Optional stall counter output under MS_PERF_CNT_EN.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  es_ms_if.slave      es,
  ms_ws_if.master     ws,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic [37:0] ms_fwd_collect,
  output logic        ms_ld_pending
`ifdef MS_PERF_CNT_EN
  ,
  output logic [31:0] ms_stall_cnt
`endif
);

  logic        ms_valid;
  logic [31:0] pc_r;
  logic [37:0] rf_r;
  logic [5:0]  mem_r;
  logic        buf_valid;
  logic [31:0] buf_data;

  logic        req_sent;
  logic [2:0]  ld_op;
  logic [1:0]  addr_lo;
  logic        op_b, op_h, op_w, op_bu, op_hu;
  logic        is_load;
  logic        ld_wait;
  logic        ready_go;
  logic        allowin;
  logic        to_ws_valid;
  logic [31:0] src;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] wdata;

  assign req_sent = mem_r[5];
  assign ld_op    = mem_r[4:2];
  assign addr_lo  = mem_r[1:0];

  assign op_b  = ld_op == 3'b001;
  assign op_h  = ld_op == 3'b010;
  assign op_w  = ld_op == 3'b011;
  assign op_bu = ld_op == 3'b101;
  assign op_hu = ld_op == 3'b110;
  assign is_load = op_b | op_h | op_w | op_bu | op_hu;

  assign ld_wait     = ms_valid & req_sent & is_load;
  assign ready_go    = ~ld_wait | data_sram_data_ok | buf_valid;
  assign allowin     = ~ms_valid | (ready_go & ws.ws_allowin);
  assign to_ws_valid = ms_valid & ready_go;

  assign es.ms_allowin    = allowin;
  assign ws.ms_to_ws_valid = to_ws_valid;
  assign ws.ms_pc         = pc_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid <= 1'b0;
      pc_r     <= '0;
      rf_r     <= '0;
      mem_r    <= '0;
    end else if (allowin) begin
      ms_valid <= es.es_to_ms_valid;
      if (es.es_to_ms_valid) begin
        pc_r  <= es.es_pc;
        rf_r  <= es.es_rf_collect;
        mem_r <= es.es_mem_collect;
      end
    end
  end

  // Holds a response that arrived while WB was stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_data  <= '0;
    end else if (to_ws_valid & ws.ws_allowin) begin
      buf_valid <= 1'b0;
    end else if (ld_wait & data_sram_data_ok &
                 ~ws.ws_allowin & ~buf_valid) begin
      buf_valid <= 1'b1;
      buf_data  <= data_sram_rdata;
    end
  end

  assign src     = buf_valid ? buf_data : data_sram_rdata;
  assign ld_half = addr_lo[1] ? src[31:16] : src[15:0];

  always_comb begin
    ld_byte = src[7:0];
    unique case (addr_lo)
      2'b00: ld_byte = src[7:0];
      2'b01: ld_byte = src[15:8];
      2'b10: ld_byte = src[23:16];
      2'b11: ld_byte = src[31:24];
      default: ld_byte = src[7:0];
    endcase
  end

  always_comb begin
    ld_ext = '0;
    unique case (1'b1)
      op_b:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      op_bu: ld_ext = {24'h0, ld_byte};
      op_h:  ld_ext = {{16{ld_half[15]}}, ld_half};
      op_hu: ld_ext = {16'h0, ld_half};
      op_w:  ld_ext = src;
      default: ld_ext = '0;
    endcase
  end

  assign wdata = is_load ? ld_ext : rf_r[31:0];

  assign ws.ms_rf_collect = {rf_r[37:32], wdata};
  assign ms_fwd_collect   = {ms_valid & rf_r[37], rf_r[36:32], wdata};
  assign ms_ld_pending    = ld_wait & ~data_sram_data_ok & ~buf_valid;

`ifdef MS_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      ms_stall_cnt <= '0;
    else if (ms_valid & ~ready_go)
      ms_stall_cnt <= ms_stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: vector table, scoreboard queue, corner sequences.
// Stall-counter checks are enabled by MS_PERF_CNT_EN.
module tb_mem_stage;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  es_ms_if es ();
  ms_ws_if ws ();

  logic        data_ok;
  logic [31:0] rdata;
  logic [37:0] fwd;
  logic        pend;
`ifdef MS_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] cnt0;
`endif

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .es                (es),
    .ws                (ws),
    .data_sram_data_ok (data_ok),
    .data_sram_rdata   (rdata),
    .ms_fwd_collect    (fwd),
    .ms_ld_pending     (pend)
`ifdef MS_PERF_CNT_EN
    ,
    .ms_stall_cnt      (stall_cnt)
`endif
  );

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  lo;
    logic        req;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [31:0] exp;
    int          dly;
  } vec_t;

  vec_t       v [12];
  logic [37:0] sb [$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [4:0] wa,
                       input logic [31:0] alu, input logic req,
                       input logic [2:0] op, input logic [1:0] lo,
                       input logic [31:0] exp);
    es.es_to_ms_valid = 1'b1;
    es.es_pc          = pc;
    es.es_rf_collect  = {1'b1, wa, alu};
    es.es_mem_collect = {req, op, lo};
    sb.push_back({1'b1, wa, exp});
  endtask

  task automatic expect_out(input string name, input logic [31:0] pc,
                            input bit pop);
    logic [37:0] e;
    chk({name, ".valid"}, 64'(ws.ms_to_ws_valid), 64'd1);
    chk({name, ".pc"}, 64'(ws.ms_pc), 64'(pc));
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s.sb actual=empty required=entry", name);
    end else begin
      e = sb[0];
      if (pop) void'(sb.pop_front());
      chk({name, ".rf"}, 64'(ws.ms_rf_collect), 64'(e));
      chk({name, ".fwd"}, 64'(fwd), 64'(e));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    v[0]  = '{3'b000, 2'b00, 1'b0, 32'h0, 32'h12345678, 32'h12345678, 0};
    v[1]  = '{3'b001, 2'b11, 1'b1, 32'h80FF0011, 32'h0, 32'hFFFFFF80, 3};
    v[2]  = '{3'b101, 2'b11, 1'b1, 32'h80FF0011, 32'h0, 32'h00000080, 3};
    v[3]  = '{3'b010, 2'b10, 1'b1, 32'h8001ABCD, 32'h0, 32'hFFFF8001, 1};
    v[4]  = '{3'b110, 2'b00, 1'b1, 32'h8001ABCD, 32'h0, 32'h0000ABCD, 0};
    v[5]  = '{3'b011, 2'b00, 1'b1, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 2};
    v[6]  = '{3'b001, 2'b00, 1'b1, 32'h8001ABCD, 32'h0, 32'hFFFFFFCD, 0};
    v[7]  = '{3'b001, 2'b01, 1'b1, 32'h8001ABCD, 32'h0, 32'hFFFFFFAB, 1};
    v[8]  = '{3'b101, 2'b10, 1'b1, 32'h8001ABCD, 32'h0, 32'h00000001, 0};
    v[9]  = '{3'b100, 2'b00, 1'b1, 32'hFFFFFFFF, 32'hCAFE0000, 32'hCAFE0000, 0};
    v[10] = '{3'b111, 2'b01, 1'b1, 32'hFFFFFFFF, 32'h00C0FFEE, 32'h00C0FFEE, 0};
    v[11] = '{3'b010, 2'b00, 1'b0, 32'h0, 32'h0BAD0001, 32'h00000001, 0};

    reset = 1'b1;
    es.es_to_ms_valid = 1'b0;
    es.es_pc = '0;
    es.es_rf_collect = '0;
    es.es_mem_collect = '0;
    ws.ws_allowin = 1'b1;
    data_ok = 1'b0;
    rdata = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst.valid", 64'(ws.ms_to_ws_valid), 64'd0);
    chk("rst.allowin", 64'(es.ms_allowin), 64'd1);
    chk("rst.pend", 64'(pend), 64'd0);
    chk("rst.rf", 64'(ws.ms_rf_collect), 64'd0);
    chk("rst.fwd", 64'(fwd), 64'd0);
`ifdef MS_PERF_CNT_EN
    chk("rst.cnt", 64'(stall_cnt), 64'd0);
`endif
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      logic [31:0] pc;
      bit waits;
      pc = 32'h1c000000 + 32'(i * 4);
      waits = v[i].req &&
              (v[i].op inside {3'b001, 3'b010, 3'b011, 3'b101, 3'b110});
      @(negedge clk);
      // v[11] has req_sent=0 so its load data comes from the bus as-is
      if (i == 11) rdata = 32'h00000001;
      drive(pc, 5'(i + 3), v[i].alu, v[i].req, v[i].op, v[i].lo, v[i].exp);
      #1 chk("vec.allowin", 64'(es.ms_allowin), 64'd1);
      @(posedge clk);
      @(negedge clk);
      es.es_to_ms_valid = 1'b0;
`ifdef MS_PERF_CNT_EN
      cnt0 = stall_cnt;
`endif
      if (waits) begin
        for (int k = 0; k < v[i].dly; k++) begin
          #1;
          chk("vec.pend", 64'(pend), 64'd1);
          chk("vec.stall", 64'(ws.ms_to_ws_valid), 64'd0);
          @(posedge clk);
          @(negedge clk);
        end
        data_ok = 1'b1;
        rdata = v[i].rdata;
        #1;
        chk("vec.pend_done", 64'(pend), 64'd0);
      end else begin
        if (i != 11) rdata = 32'hA5A5A5A5;
        #1;
        chk("vec.nowait", 64'(pend), 64'd0);
      end
      expect_out($sformatf("vec%0d", i), pc, 1'b1);
      @(posedge clk);
      @(negedge clk);
      data_ok = 1'b0;
`ifdef MS_PERF_CNT_EN
      chk("vec.cnt", 64'(stall_cnt - cnt0), 64'(waits ? v[i].dly : 0));
`endif
      #1 chk("vec.gone", 64'(ws.ms_to_ws_valid), 64'd0);
    end

    // WB stall with response: buffer must hold data after bus changes
    @(negedge clk);
    drive(32'h1c001000, 5'd9, 32'h0, 1'b1, 3'b011, 2'b00, 32'hDEADBEEF);
    @(posedge clk);
    @(negedge clk);
    es.es_to_ms_valid = 1'b0;
    ws.ws_allowin = 1'b0;
    data_ok = 1'b1;
    rdata = 32'hDEADBEEF;
    #1;
    chk("buf.allowin0", 64'(es.ms_allowin), 64'd0);
    expect_out("buf0", 32'h1c001000, 1'b0);
    @(posedge clk);
    @(negedge clk);
    data_ok = 1'b0;
    rdata = 32'h0;
    #1;
    chk("buf.pend", 64'(pend), 64'd0);
    expect_out("buf1", 32'h1c001000, 1'b0);
    @(posedge clk);
    @(negedge clk);
    ws.ws_allowin = 1'b1;
    drive(32'h1c001004, 5'd10, 32'h0, 1'b1, 3'b001, 2'b00, 32'hFFFFFF80);
    #1;
    chk("buf.allowin1", 64'(es.ms_allowin), 64'd1);
    expect_out("buf2", 32'h1c001000, 1'b1);
    @(posedge clk);
    @(negedge clk);
    es.es_to_ms_valid = 1'b0;
    #1;
    chk("b2b.pend", 64'(pend), 64'd1);
    chk("b2b.stall", 64'(ws.ms_to_ws_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    data_ok = 1'b1;
    rdata = 32'h00000080;
    #1 expect_out("b2b.load", 32'h1c001004, 1'b1);
    @(posedge clk);
    @(negedge clk);
    data_ok = 1'b0;
    #1 chk("b2b.gone", 64'(ws.ms_to_ws_valid), 64'd0);

    // Back-to-back non-loads
    @(negedge clk);
    drive(32'h1c002000, 5'd11, 32'h11111111, 1'b0, 3'b000, 2'b00,
          32'h11111111);
    @(posedge clk);
    @(negedge clk);
    drive(32'h1c002004, 5'd12, 32'h22222222, 1'b0, 3'b000, 2'b00,
          32'h22222222);
    #1 expect_out("nl.a", 32'h1c002000, 1'b1);
    @(posedge clk);
    @(negedge clk);
    es.es_to_ms_valid = 1'b0;
    #1 expect_out("nl.b", 32'h1c002004, 1'b1);

    // Reset during a pending load drops it
    @(negedge clk);
    drive(32'h1c003000, 5'd13, 32'h0, 1'b1, 3'b010, 2'b00, 32'h0);
    @(posedge clk);
    @(negedge clk);
    es.es_to_ms_valid = 1'b0;
    #1 chk("rmw.pend", 64'(pend), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    void'(sb.pop_back());
    #1;
    chk("rmw.valid", 64'(ws.ms_to_ws_valid), 64'd0);
    chk("rmw.allowin", 64'(es.ms_allowin), 64'd1);
    chk("rmw.pend", 64'(pend), 64'd0);
`ifdef MS_PERF_CNT_EN
    chk("rmw.cnt", 64'(stall_cnt), 64'd0);
`endif

    // Stray data_ok with MEM empty
    @(negedge clk);
    data_ok = 1'b1;
    rdata = 32'h55AA55AA;
    #1;
    chk("stray.valid", 64'(ws.ms_to_ws_valid), 64'd0);
    chk("stray.pend", 64'(pend), 64'd0);
    chk("stray.allowin", 64'(es.ms_allowin), 64'd1);
    @(posedge clk);
    @(negedge clk);
    data_ok = 1'b0;
    rdata = 32'h0;
    drive(32'h1c004000, 5'd14, 32'h0, 1'b1, 3'b011, 2'b00, 32'h01234567);
    @(posedge clk);
    @(negedge clk);
    es.es_to_ms_valid = 1'b0;
    #1;
    chk("stray.nobuf", 64'(pend), 64'd1);
    chk("stray.stall", 64'(ws.ms_to_ws_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    data_ok = 1'b1;
    rdata = 32'h01234567;
    #1 expect_out("stray.load", 32'h1c004000, 1'b1);
    @(posedge clk);
    @(negedge clk);
    data_ok = 1'b0;
    #1 chk("sb.empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
